// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   fetch_entry_t : one prefetch-queue entry, the fetch PC and its instruction word
//   IF_PC_STEP    : distance between consecutive sequential fetch addresses
package if_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] IF_PC_STEP = 32'd4;

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Bus bundle between the fetch front end, instruction memory, branch
// resolution and the ID stage.
//   im_addr / im_rdata          : synchronous-read instruction memory (data one cycle after address)
//   redir_valid / redir_pc      : redirect request and word-aligned target
//   id_valid / id_ready         : head-of-queue handshake to ID
//   id_pc / id_pc4 / id_instr   : head entry contents
//   perf_fetch_cnt / perf_starve_cnt : optional performance counters
// master = fetch unit side, slave = surrounding core / memory side.
interface if_prefetch_unit_if;

    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_starve_cnt;

    modport master (
        output im_addr,
        input  im_rdata,
        input  redir_valid,
        input  redir_pc,
        output id_valid,
        input  id_ready,
        output id_pc,
        output id_pc4,
        output id_instr,
        output perf_fetch_cnt,
        output perf_starve_cnt
    );

    modport slave (
        input  im_addr,
        output im_rdata,
        output redir_valid,
        output redir_pc,
        input  id_valid,
        output id_ready,
        input  id_pc,
        input  id_pc4,
        input  id_instr,
        input  perf_fetch_cnt,
        input  perf_starve_cnt
    );

endinterface

// File: rtl/if_prefetch_unit_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t used as the prefetch queue.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : drop all contents (wins over push/pop)
//   push      : write push_data at the tail
//   pop       : advance the head
//   head      : current head entry (valid only when count != 0)
//   count     : number of stored entries, 0..DEPTH
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]     count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // The issue accounting upstream must never let a response land in a full queue.
    always @(posedge clk) begin
        if (!rst && push && !flush) begin
            assert (count_q != (PW+1)'(DEPTH));
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: PC generator, synchronous-read instruction-memory requester
// and DEPTH-entry prefetch queue feeding the ID stage over valid/ready.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : if_prefetch_unit_if.master (memory, redirect, ID handshake, perf counters)
// Parameters: DEPTH (queue entries, power of two >= 2), RESET_PC (first fetch address).
// Optional build macro IF_PERF_CNT_EN adds delivered/starved cycle counters;
// without it both perf ports are tied to zero.
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    if_prefetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         req_q, req_d;
    logic [31:0]  im_addr;
    logic [CW-1:0] count;
    logic [CW:0]  pending;
    logic         deq, push, issue, id_valid;
    fetch_entry_t head, push_data;

    // A redirect hides the head and discards the response of the old stream.
    assign id_valid  = (count != '0) && !bus.redir_valid;
    assign deq       = id_valid && bus.id_ready;
    assign push      = req_q && !bus.redir_valid;
    assign push_data = '{pc: req_pc_q, instr: bus.im_rdata};

    // Slots committed after this edge: stored entries plus the in-flight one, less a pop.
    // Issuing only while this is below DEPTH guarantees room when the response arrives.
    assign pending = {1'b0, count} + {{CW{1'b0}}, req_q} - {{CW{1'b0}}, deq};
    assign issue   = (pending < (CW+1)'(DEPTH)) && !bus.redir_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        req_d      = 1'b0;
        im_addr    = fetch_pc_q;
        if (bus.redir_valid) begin
            im_addr    = bus.redir_pc;
            req_d      = 1'b1;
            req_pc_d   = bus.redir_pc;
            fetch_pc_d = bus.redir_pc + IF_PC_STEP;
        end else if (issue) begin
            req_d      = 1'b1;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + IF_PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            req_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            req_q      <= req_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redir_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (deq),
        .head      (head),
        .count     (count)
    );

    assign bus.im_addr  = im_addr;
    assign bus.id_valid = id_valid;
    assign bus.id_pc    = head.pc;
    assign bus.id_pc4   = head.pc + IF_PC_STEP;
    assign bus.id_instr = head.instr;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_starve_q, perf_starve_d;
    logic        starve;

    assign starve = bus.id_ready && !id_valid && !bus.redir_valid;

    always_comb begin
        perf_fetch_d  = perf_fetch_q + {31'b0, deq};
        perf_starve_d = perf_starve_q + {31'b0, starve};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q  <= '0;
            perf_starve_q <= '0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_starve_q <= perf_starve_d;
        end
    end

    assign bus.perf_fetch_cnt  = perf_fetch_q;
    assign bus.perf_starve_cnt = perf_starve_q;
`else
    assign bus.perf_fetch_cnt  = 32'h0;
    assign bus.perf_starve_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: two instances (RESET_PC 0 and FFFF_FFF8),
// memory returns word = address one cycle late, scoreboard queues of expected
// deliveries popped by a negedge monitor on every accepted head.
module tb_if_prefetch_unit;
    import if_pkg::*;

`ifdef IF_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    fetch_entry_t sb0[$];
    fetch_entry_t sb1[$];

    if_prefetch_unit_if bus0 ();
    if_prefetch_unit_if bus1 ();

    if_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    if_prefetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word content equals its address, registered read.
    always @(posedge clk) begin
        bus0.im_rdata <= bus0.im_addr;
        bus1.im_rdata <= bus1.im_addr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push0(input logic [31:0] pc);
        sb0.push_back('{pc: pc, instr: pc});
    endtask

    task automatic push1(input logic [31:0] pc);
        sb1.push_back('{pc: pc, instr: pc});
    endtask

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic settle();
        #2;
    endtask

    // Monitor: every accepted head must match the next scoreboard entry.
    always @(negedge clk) begin
        fetch_entry_t e;
        if (bus0.id_valid && bus0.id_ready) begin
            if (sb0.size() == 0) begin
                chk("sb0_unexpected_pc", bus0.id_pc, 32'hxxxx_xxxx);
            end else begin
                e = sb0.pop_front();
                chk("sb0_pc", bus0.id_pc, e.pc);
                chk("sb0_pc4", bus0.id_pc4, e.pc + 32'd4);
                chk("sb0_instr", bus0.id_instr, e.instr);
            end
        end
        if (bus1.id_valid && bus1.id_ready) begin
            if (sb1.size() == 0) begin
                chk("sb1_unexpected_pc", bus1.id_pc, 32'hxxxx_xxxx);
            end else begin
                e = sb1.pop_front();
                chk("sb1_pc", bus1.id_pc, e.pc);
                chk("sb1_pc4", bus1.id_pc4, e.pc + 32'd4);
                chk("sb1_instr", bus1.id_instr, e.instr);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus0.id_ready    = 1'b1;
        bus0.redir_valid = 1'b0;
        bus0.redir_pc    = 32'h0;
        bus1.id_ready    = 1'b0;
        bus1.redir_valid = 1'b0;
        bus1.redir_pc    = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_id_valid", {31'b0, bus0.id_valid}, 32'd0);
        chk("rst_id_pc", bus0.id_pc, 32'h0);
        chk("rst_id_pc4", bus0.id_pc4, 32'h4);
        chk("rst_id_instr", bus0.id_instr, 32'h0);
        chk("rst_im_addr", bus0.im_addr, 32'h0);
        chk("rst_im_addr_dut1", bus1.im_addr, 32'hFFFF_FFF8);
        chk("rst_perf_fetch", bus0.perf_fetch_cnt, 32'h0);
        chk("rst_perf_starve", bus0.perf_starve_cnt, 32'h0);

        // Phase 1: streaming, redirect, fill, redirect while full.
        for (int i = 0; i < 5; i++) push0(32'(i * 4));
        rst = 1'b0;
        cyc = 0;
        settle();
        chk("c0_id_valid", {31'b0, bus0.id_valid}, 32'd0);
        chk("c0_im_addr", bus0.im_addr, 32'h0);
        step_to(1); settle();
        chk("c1_id_valid", {31'b0, bus0.id_valid}, 32'd0);
        chk("c1_im_addr", bus0.im_addr, 32'h4);
        for (int k = 2; k <= 6; k++) begin
            step_to(k); settle();
            chk("stream_id_valid", {31'b0, bus0.id_valid}, 32'd1);
            if (k == 2) chk("c2_id_pc", bus0.id_pc, 32'h0);
        end

        step_to(7);
        bus0.redir_valid = 1'b1;
        bus0.redir_pc    = 32'h200;
        for (int i = 0; i < 4; i++) push0(32'h200 + 32'(i * 4));
        settle();
        chk("redir_c7_id_valid", {31'b0, bus0.id_valid}, 32'd0);
        chk("redir_c7_im_addr", bus0.im_addr, 32'h200);
        step_to(8);
        bus0.redir_valid = 1'b0;
        settle();
        chk("redir_c8_id_valid", {31'b0, bus0.id_valid}, 32'd0);
        step_to(9); settle();
        chk("redir_c9_id_valid", {31'b0, bus0.id_valid}, 32'd1);
        chk("redir_c9_id_pc", bus0.id_pc, 32'h200);
        chk("redir_c9_id_instr", bus0.id_instr, 32'h200);

        step_to(13);
        bus0.id_ready = 1'b0;
        settle();
        chk("sb0_drained_p1a", 32'(sb0.size()), 32'd0);
        chk("stall_head_pc", bus0.id_pc, 32'h210);
        step_to(19); settle();
        chk("full_im_addr", bus0.im_addr, 32'h220);
        chk("full_id_pc", bus0.id_pc, 32'h210);
        chk("full_id_valid", {31'b0, bus0.id_valid}, 32'd1);

        step_to(20);
        bus0.redir_valid = 1'b1;
        bus0.redir_pc    = 32'h400;
        settle();
        chk("fullredir_id_valid", {31'b0, bus0.id_valid}, 32'd0);
        chk("fullredir_im_addr", bus0.im_addr, 32'h400);
        step_to(21);
        bus0.redir_valid = 1'b0;
        bus0.id_ready    = 1'b1;
        push0(32'h400);
        push0(32'h404);
        settle();
        chk("fullredir_emptied", {31'b0, bus0.id_valid}, 32'd0);
        step_to(22); settle();
        chk("fullredir_head_pc", bus0.id_pc, 32'h400);
        step_to(24);
        bus0.id_ready = 1'b0;
        settle();
        chk("sb0_drained_p1b", 32'(sb0.size()), 32'd0);
        chk("perf_fetch_p1", bus0.perf_fetch_cnt, PERF_EN ? 32'd11 : 32'd0);
        chk("perf_starve_p1", bus0.perf_starve_cnt, PERF_EN ? 32'd4 : 32'd0);

        // Phase 2: asynchronous reset mid-stream, then back-pressure fill and wrap test.
        rst = 1'b1;
        #1;
        chk("async_rst_id_valid", {31'b0, bus0.id_valid}, 32'd0);
        chk("async_rst_im_addr", bus0.im_addr, 32'h0);
        chk("async_rst_perf_fetch", bus0.perf_fetch_cnt, 32'h0);
        chk("async_rst_perf_starve", bus0.perf_starve_cnt, 32'h0);
        sb0.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        bus0.id_ready = 1'b1;
        bus1.id_ready = 1'b1;
        for (int i = 0; i < 5; i++) push0(32'(i * 4));
        push1(32'hFFFF_FFF8);
        push1(32'hFFFF_FFFC);
        push1(32'h0000_0000);

        step_to(2);
        bus0.id_ready = 1'b0;
        settle();
        chk("wrap_c2_id_pc", bus1.id_pc, 32'hFFFF_FFF8);
        step_to(3); settle();
        chk("wrap_c3_id_pc", bus1.id_pc, 32'hFFFF_FFFC);
        chk("wrap_c3_id_pc4", bus1.id_pc4, 32'h0);
        step_to(4); settle();
        chk("wrap_c4_id_pc", bus1.id_pc, 32'h0);
        step_to(5);
        bus1.id_ready = 1'b0;
        settle();
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        chk("stall_c5_im_addr", bus0.im_addr, 32'h10);
        step_to(11); settle();
        chk("stall_c11_im_addr", bus0.im_addr, 32'h10);
        chk("stall_c11_id_pc", bus0.id_pc, 32'h0);
        chk("stall_c11_id_valid", {31'b0, bus0.id_valid}, 32'd1);
        step_to(12);
        bus0.id_ready = 1'b1;
        settle();
        step_to(13); settle();
        chk("resume_c13_im_addr", bus0.im_addr, 32'h14);
        step_to(17);
        bus0.id_ready = 1'b0;
        settle();
        chk("sb0_drained_p2", 32'(sb0.size()), 32'd0);
        chk("perf_fetch_p2", bus0.perf_fetch_cnt, PERF_EN ? 32'd5 : 32'd0);
        chk("perf_starve_p2", bus0.perf_starve_cnt, PERF_EN ? 32'd2 : 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_prefetch_unit.md
# if_prefetch_unit

Parametrised instruction-fetch front end for the pipelined RV32 core. It replaces the single-register PC/IF-ID path with a PC generator, a synchronous-read instruction-memory interface and a DEPTH-entry prefetch queue. It hands {pc, pc4, instr} to the ID stage over a valid/ready handshake, and accepts branch/jump redirects that flush all queued and in-flight fetches.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- im_addr  out  32  instruction-memory address; memory samples every cycle
- im_rdata  in  32  instruction word, valid the cycle after its address
- redir_valid  in  1  redirect request from branch resolution
- redir_pc  in  32  redirect target; must be word-aligned
- id_valid  out  1  queue head valid
- id_ready  in  1  ID stage accepts head
- id_pc  out  32  head PC
- id_pc4  out  32  head PC + 4
- id_instr  out  32  head instruction
- perf_fetch_cnt  out  32  instructions delivered; 0 unless IF_PERF_CNT_EN
- perf_starve_cnt  out  32  starved cycles; 0 unless IF_PERF_CNT_EN

## Operation
- State: fetch_pc, req_q (one fetch in flight), req_pc_q (its PC), queue with rd/wr pointers of log2(DEPTH) bits, count of log2(DEPTH)+1 bits.
- deq = id_valid & id_ready & !redir_valid.
- Normal issue when (count + req_q − deq) < DEPTH and !redir_valid:
  - im_addr = fetch_pc
  - fetch_pc ← fetch_pc + 4
  - req_q ← 1, req_pc_q ← fetch_pc
- If the issue condition is false: im_addr = fetch_pc, and req_q ← 0.
- Response: when req_q=1, {req_pc_q, im_rdata} is written at the queue tail on that cycle's edge.
- Redirect has absolute priority. In the redirect cycle:
  - id_valid forced 0, no dequeue
  - in-flight response discarded, queue cleared (count ← 0, pointers ← 0)
  - im_addr = redir_pc, req_q ← 1, req_pc_q ← redir_pc, fetch_pc ← redir_pc + 4
- Simultaneous enqueue and dequeue: both take effect; count unchanged.
- The issue accounting guarantees no enqueue while full. Enqueue-when-full is an assertion failure.
- id_pc4 = id_pc + 4, combinational from the head entry.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC wraps to 0 with no flag.
- id_* outputs are the head entry regardless of id_valid. Outputs are stable while id_valid=1 and id_ready=0.

## Timing
- Reset values:
  - id_valid 0; id_pc, id_instr 0; id_pc4 4
  - im_addr RESET_PC, fetch_pc RESET_PC
  - req_q 0, count 0, perf counters 0
- Reset asserted mid-operation clears all state immediately, with no partial delivery.
- First issue occurs in the first cycle after rst deasserts (cycle 0); id_valid is first high in cycle 2.
- Fetch latency: address in cycle N, data on im_rdata in N+1, enqueued at the end of N+1, head visible in N+2 if the queue was empty.
- Redirect in cycle R: id_valid=0 in R and R+1; id_pc=redir_pc with id_valid=1 in R+2.
- Sustained throughput is 1 instr/cycle with id_ready held high.
- With id_ready low, the queue fills to DEPTH and issue stops. When id_ready rises, issue resumes in the same cycle.

## Configuration
- IF_PERF_CNT_EN defined:
  - perf_fetch_cnt increments on every deq.
  - perf_starve_cnt increments each cycle with id_ready=1, id_valid=0 and !redir_valid.
  - Both are 32-bit, wrap on overflow, and clear on rst.
- Undefined: no counter flops are built and both ports are tied to 32'h0.

## Structure
- Package if_pkg holds:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}
  - constant IF_PC_STEP = 32'd4
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Parameters: DEPTH.
  - Ports: clk, rst, flush, push, push_data, pop, head, count.
- The top level holds the PC, in-flight tracking, issue accounting and the optional counters.

## Test plan
- Reset release, id_ready=1, memory word = address → id_valid first high cycle 2 with id_pc=0, then id_pc 4, 8, 12 on consecutive cycles; no bubbles.
- id_ready=0 from cycle 2 for 10 cycles, DEPTH=4 → count saturates at 4; im_addr holds 32'h10. After id_ready=1, delivers 0, 4, 8, 12, 16 in order with no duplication or loss.
- redir_valid=1 with redir_pc=32'h200 in cycle 7 → no id_valid in cycles 7–8; cycle 9 id_pc=32'h200, id_instr=32'h200, then 32'h204. No pre-redirect PC is ever delivered.
- Redirect while the queue is full and id_ready=0 → queue empties. The first head after the redirect is redir_pc, two cycles later.
- RESET_PC=32'hFFFF_FFF8 → delivers FFFF_FFF8, FFFF_FFFC, 0000_0000; id_pc4 of FFFF_FFFC is 0.
- rst pulsed asynchronously mid-stream with IF_PERF_CNT_EN defined → id_valid drops immediately and perf counters read 0. Without the macro, both perf ports read 0 throughout.
